// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: FSM states, display codes, default widths.
// Pure declarations; no timing or flow-control behaviour of its own.
package calc_pkg;

  localparam int W_DEF       = 8;
  localparam int OPW_DEF     = 2;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_RUN  = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [1:0] DISP_SW  = 2'd0;
  localparam logic [1:0] DISP_RES = 2'd1;
  localparam logic [1:0] DISP_ERR = 2'd2;

  function automatic logic [1:0] disp_code(input state_t s);
    case (s)
      S_SHOW:  disp_code = DISP_RES;
      S_ERR:   disp_code = DISP_ERR;
      default: disp_code = DISP_SW;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button synchroniser + rising-edge detector; one-cycle evt, 3 clk edges after the press.
// No backpressure: an event not consumed in its cycle is lost; holding the button adds nothing.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic sync1, sync2, dly;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
      evt   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      dly   <= sync2;
      evt   <= sync2 & ~dly;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator entry sequencer: A, op, B, ALU run, show; owns operand/opcode/result registers.
// Events act on the edge after they appear; no backpressure, events ignored in a state are dropped.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   sw,
  input  logic [OPW-1:0] op_sel,
  input  logic           btn_enter,
  input  logic           btn_eq,
  input  logic           btn_clr,
  input  logic [W-1:0]   alu_res,
  input  logic           alu_done,
  input  logic           alu_err,
  output logic [W-1:0]   a_reg,
  output logic [W-1:0]   b_reg,
  output logic [OPW-1:0] op_reg,
  output logic           alu_start,
  output logic [W-1:0]   res_reg,
  output logic [1:0]     disp_sel,
  output logic           busy,
  output logic           err,
  output logic [2:0]     state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        st;
  logic [CW-1:0] cnt;
  logic          ev_enter, ev_eq, ev_clr;

  btn_edge u_enter (.clk(clk), .rst(rst), .btn(btn_enter), .evt(ev_enter));
  btn_edge u_eq    (.clk(clk), .rst(rst), .btn(btn_eq),    .evt(ev_eq));
  btn_edge u_clr   (.clk(clk), .rst(rst), .btn(btn_clr),   .evt(ev_clr));

  // clr outranks everything; within a state eq is tested before enter so
  // a coincident lower-priority event is simply dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= S_A;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      res_reg   <= '0;
      alu_start <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      if (ev_clr) begin
        st      <= S_A;
        cnt     <= '0;
        a_reg   <= '0;
        b_reg   <= '0;
        op_reg  <= '0;
        res_reg <= '0;
      end else begin
        case (st)
          S_A: begin
            if (ev_enter) begin
              a_reg <= sw;
              st    <= S_OP;
            end
          end
          S_OP: begin
            if (ev_enter) begin
              op_reg <= op_sel;
              st     <= S_B;
            end
          end
          S_B: begin
            if (ev_eq || ev_enter) begin
              b_reg     <= sw;
              st        <= S_RUN;
              alu_start <= 1'b1;
              cnt       <= '0;
            end
          end
          S_RUN: begin
            // A done arriving on the final timeout cycle still wins.
            if (alu_done) begin
              if (alu_err) begin
                st <= S_ERR;
              end else begin
                res_reg <= alu_res;
                st      <= S_SHOW;
              end
            end else if (cnt == TO_LAST) begin
              st <= S_ERR;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SHOW: begin
            if (ev_eq) begin
              a_reg     <= res_reg;
              st        <= S_RUN;
              alu_start <= 1'b1;
              cnt       <= '0;
            end else if (ev_enter) begin
              a_reg <= res_reg;
              st    <= S_OP;
            end
          end
          S_ERR:   st <= S_ERR;
          default: st <= S_A;
        endcase
      end
    end
  end

  assign state    = st;
  assign disp_sel = disp_code(st);
  assign busy     = (st == S_RUN);
  assign err      = (st == S_ERR);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl; expected ALU launches and result displays are queued by the
// stimulus and popped by an independent monitor when the DUT presents them.
module tb_calc_seq_ctrl;

  localparam int W = 8;
  localparam int OPW = 2;
  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPW-1:0] op;
  } start_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic [1:0]   disp;
    logic         e;
  } res_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   sw = '0;
  logic [OPW-1:0] op_sel = '0;
  logic           btn_enter = 1'b0, btn_eq = 1'b0, btn_clr = 1'b0;
  logic [W-1:0]   alu_res = '0;
  logic           alu_done = 1'b0, alu_err = 1'b0;
  logic [W-1:0]   a_reg, b_reg, res_reg;
  logic [OPW-1:0] op_reg;
  logic           alu_start, busy, err;
  logic [1:0]     disp_sel;
  logic [2:0]     state;

  int n_chk = 0;
  int n_fail = 0;
  start_t start_q[$];
  res_t   res_q[$];
  start_t s_exp;
  res_t   r_exp;
  logic [2:0] prev_st = 3'd0;

  calc_seq_ctrl #(.W(W), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sw(sw), .op_sel(op_sel),
    .btn_enter(btn_enter), .btn_eq(btn_eq), .btn_clr(btn_clr),
    .alu_res(alu_res), .alu_done(alu_done), .alu_err(alu_err),
    .a_reg(a_reg), .b_reg(b_reg), .op_reg(op_reg), .alu_start(alu_start),
    .res_reg(res_reg), .disp_sel(disp_sel), .busy(busy), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // which: 0=enter, 1=eq, 2=clr. Returns one edge after the state update.
  task automatic press(input int which);
    case (which)
      0: btn_enter = 1'b1;
      1: btn_eq = 1'b1;
      default: btn_clr = 1'b1;
    endcase
    wait_cyc(2);
    btn_enter = 1'b0;
    btn_eq = 1'b0;
    btn_clr = 1'b0;
    wait_cyc(3);
  endtask

  task automatic alu_reply(input logic [W-1:0] r, input logic e);
    alu_res = r;
    alu_err = e;
    alu_done = 1'b1;
    wait_cyc(1);
    alu_done = 1'b0;
    alu_err = 1'b0;
  endtask

  // Monitor: every alu_start and every entry into SHOW/ERR must match a queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (alu_start) begin
        if (start_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_start: got alu_start=1, expected none");
        end else begin
          s_exp = start_q.pop_front();
          chk("start_a", 32'(a_reg), 32'(s_exp.a));
          chk("start_b", 32'(b_reg), 32'(s_exp.b));
          chk("start_op", 32'(op_reg), 32'(s_exp.op));
        end
      end
      if (state != prev_st && (state == 3'd4 || state == 3'd5)) begin
        if (res_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got state=%0d, expected no result", state);
        end else begin
          r_exp = res_q.pop_front();
          chk("res_reg", 32'(res_reg), 32'(r_exp.res));
          chk("res_disp", 32'(disp_sel), 32'(r_exp.disp));
          chk("res_err", 32'(err), 32'(r_exp.e));
        end
      end
    end
    prev_st = state;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    wait_cyc(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_regs", {a_reg, b_reg, res_reg, 6'b0, op_reg}, 0);
    chk("rst_outs", {28'b0, alu_start, busy, err, |disp_sel}, 0);
    rst = 1'b1;
    wait_cyc(2);

    // 12 + 5 -> 17
    sw = 8'd12;
    press(0);
    chk("a_load_state", 32'(state), 1);
    chk("a_load", 32'(a_reg), 12);
    op_sel = 2'd0;
    press(0);
    chk("op_state", 32'(state), 2);
    sw = 8'd5;
    start_q.push_back('{a: 8'd12, b: 8'd5, op: 2'd0});
    res_q.push_back('{res: 8'd17, disp: 2'd1, e: 1'b0});
    press(0);
    chk("run_busy", 32'(busy), 1);
    alu_reply(8'd17, 1'b0);
    chk("show_state", 32'(state), 4);
    chk("show_disp", 32'(disp_sel), 1);

    // Repeat via eq; alu_done lands in the alu_start cycle.
    start_q.push_back('{a: 8'd17, b: 8'd5, op: 2'd0});
    res_q.push_back('{res: 8'd22, disp: 2'd1, e: 1'b0});
    btn_eq = 1'b1;
    wait_cyc(2);
    btn_eq = 1'b0;
    wait_cyc(2);
    alu_reply(8'd22, 1'b0);
    wait_cyc(1);
    chk("repeat_state", 32'(state), 4);
    chk("repeat_a", 32'(a_reg), 17);
    chk("repeat_b", 32'(b_reg), 5);
    press(0);
    chk("chain_state", 32'(state), 1);
    chk("chain_a", 32'(a_reg), 22);

    // Enter held for 40 cycles in S_B: one event, one launch.
    op_sel = 2'd2;
    press(0);
    sw = 8'd9;
    start_q.push_back('{a: 8'd22, b: 8'd9, op: 2'd2});
    res_q.push_back('{res: 8'd33, disp: 2'd1, e: 1'b0});
    btn_enter = 1'b1;
    wait_cyc(4);
    alu_reply(8'd33, 1'b0);
    wait_cyc(35);
    btn_enter = 1'b0;
    wait_cyc(4);
    chk("hold_state", 32'(state), 4);
    chk("hold_res", 32'(res_reg), 33);

    // Clear, then time out with no alu_done.
    press(2);
    chk("clr_state", 32'(state), 0);
    chk("clr_regs", {a_reg, b_reg, res_reg, 6'b0, op_reg}, 0);
    sw = 8'd3;
    press(0);
    op_sel = 2'd1;
    press(0);
    sw = 8'd4;
    start_q.push_back('{a: 8'd3, b: 8'd4, op: 2'd1});
    res_q.push_back('{res: 8'd0, disp: 2'd2, e: 1'b1});
    press(0);
    wait_cyc(2);
    chk("pre_timeout_state", 32'(state), 3);
    wait_cyc(1);
    chk("timeout_state", 32'(state), 5);
    chk("timeout_err", 32'(err), 1);
    chk("timeout_disp", 32'(disp_sel), 2);
    press(0);
    chk("err_enter_ignored", 32'(state), 5);
    press(2);
    chk("err_clr_state", 32'(state), 0);

    // Reset mid S_RUN; a later alu_done must be ignored.
    sw = 8'd7;
    press(0);
    op_sel = 2'd3;
    press(0);
    sw = 8'd8;
    start_q.push_back('{a: 8'd7, b: 8'd8, op: 2'd3});
    press(0);
    chk("pre_reset_busy", 32'(busy), 1);
    rst = 1'b0;
    wait_cyc(3);
    chk("midrun_rst_state", 32'(state), 0);
    chk("midrun_rst_regs", {a_reg, b_reg, res_reg, 6'b0, op_reg}, 0);
    chk("midrun_rst_outs", {28'b0, alu_start, busy, err, |disp_sel}, 0);
    rst = 1'b1;
    wait_cyc(1);
    alu_reply(8'd99, 1'b0);
    wait_cyc(2);
    chk("late_done_state", 32'(state), 0);
    chk("late_done_res", 32'(res_reg), 0);

    // eq ignored in S_A; clr beats a coincident enter.
    press(1);
    chk("eq_in_a", 32'(state), 0);
    sw = 8'd55;
    btn_clr = 1'b1;
    btn_enter = 1'b1;
    wait_cyc(2);
    btn_clr = 1'b0;
    btn_enter = 1'b0;
    wait_cyc(3);
    chk("clr_enter_state", 32'(state), 0);
    chk("clr_enter_a", 32'(a_reg), 0);
    press(0);
    chk("enter_after_clr_a", 32'(a_reg), 55);
    chk("enter_after_clr_state", 32'(state), 1);

    wait_cyc(2);
    chk("start_q_drained", start_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Operation sequencer for the calculator datapath. Takes raw push-button levels and switch values, turns button presses into single-cycle events through synchronising rising-edge detectors, and steps a state machine through the entry sequence: operand A, operator, operand B, ALU run, result display. It owns the operand, opcode and result registers feeding the ALU and display mux, and handles ALU handshake, timeout, error and result chaining.

## Interface
- W, 8: operand/result width
- OPW, 2: opcode width
- TIMEOUT, 255: max cycles waiting for alu_done (≥1)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- sw  in  W  operand switches, sampled directly (static during press)
- op_sel  in  OPW  operator switches
- btn_enter  in  1  raw button level, asynchronous
- btn_eq  in  1  raw button level, asynchronous
- btn_clr  in  1  raw button level, asynchronous
- alu_res  in  W  ALU result, valid with alu_done
- alu_done  in  1  ALU completion pulse
- alu_err  in  1  ALU error (div-by-0/overflow), valid with alu_done
- a_reg  out  W  operand A to ALU
- b_reg  out  W  operand B to ALU
- op_reg  out  OPW  opcode to ALU
- alu_start  out  1  one-cycle start pulse
- res_reg  out  W  latched result
- disp_sel  out  2  0=live sw, 1=res_reg, 2=error
- busy  out  1  high in S_RUN
- err  out  1  high in S_ERR
- state  out  3  current state, debug

## Operation
- Each button: 2-flop synchroniser + delay flop; event = sync & ~delayed, exactly one cycle per press regardless of hold length.
- Event priority per cycle: clr > eq > enter; lower-priority coincident events dropped, not queued.
- clr in any state: a/b/op/res cleared to 0, go S_A, alu_start not issued; an in-flight alu_done afterwards ignored.
- States: S_A(0), S_OP(1), S_B(2), S_RUN(3), S_SHOW(4), S_ERR(5).
- S_A: enter → a_reg←sw, S_OP. eq ignored.
- S_OP: enter → op_reg←op_sel, S_B. eq ignored.
- S_B: enter or eq → b_reg←sw, S_RUN.
- S_RUN: alu_start=1 on first cycle only; timeout counter cleared on entry, increments each cycle. alu_done & ~alu_err → res_reg←alu_res, S_SHOW. alu_done & alu_err → S_ERR. Counter reaching TIMEOUT without done → S_ERR. enter/eq ignored.
- S_SHOW: enter → a_reg←res_reg, S_OP (chain). eq → a_reg←res_reg, b_reg and op_reg kept, S_RUN (repeat last op).
- S_ERR: only clr exits.
- disp_sel: 1 in S_SHOW, 2 in S_ERR, 0 otherwise. busy = (state==S_RUN); err = (state==S_ERR).
- Unused encodings 6,7 → S_A next cycle.

## Timing
- Reset values: all registers 0, state S_A, alu_start/busy/err 0, disp_sel 0.
- Button rising edge to event: event high in cycle after third clk edge; state/register update on next edge.
- alu_start high exactly the cycle state first equals S_RUN; never two consecutive cycles.
- alu_done same cycle as alu_start is accepted.
- Timeout: S_ERR entered TIMEOUT cycles after S_RUN entry if no done; done on the timeout cycle wins.
- Outputs registered; no combinational path from inputs to outputs except disp_sel/busy/err/state decode from state.

## Structure
- Package calc_pkg: state encodings, disp_sel codes, default W/OPW.
- Sub-module btn_edge (sync + rising-edge pulse, clk/rst), instantiated three times.
- Timeout counter width $clog2(TIMEOUT+1).

## Test plan
- Reset mid S_RUN (rst low 3 cycles) → state 0, all outputs 0, later alu_done ignored.
- sw=12 enter, op_sel=0 enter, sw=5 enter, alu_done res=17 → one alu_start, a=12 b=5 op=0, res_reg=17, disp_sel=1.
- In S_SHOW press eq with alu_done res=22 → a_reg=17, b=5 unchanged, second alu_start, res_reg=22; then enter → a_reg=22, state S_OP.
- In S_B hold enter 40 cycles → single event, single alu_start.
- TIMEOUT=4, no alu_done → S_ERR, err=1, disp_sel=2 after 4 cycles; enter ignored; clr → S_A.
- clr and enter rising same cycle in S_A → registers 0, a_reg not loaded, state stays S_A.
